sample_dot_acc: RTL and testbench
=================================

# sample_dot_acc

Dot-product accumulation stage that drives the 14-bit signed DSP48 multiplier stage and consumes its products. It accepts operand pairs over a valid/ready handshake and feeds them to the multiplier. It tracks the multiplier's 2-cycle pipeline with a tag shift register and accumulates VEC_LEN products in a wide accumulator. Each finished vector yields one saturated DATA_WIDTH result, held until the consumer takes it.

## Interface
- DATA_WIDTH, 14: operand, product and result width (two's complement).
- ACC_WIDTH, 24: accumulator width; must satisfy ACC_WIDTH >= DATA_WIDTH + clog2(VEC_LEN).
- VEC_LEN, 16: products per result; legal range 2..1024.
- MUL_LATENCY, 2: cycles from mul_ce-qualified operands to a valid mul_dout; fixed by the multiplier.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- in_a  in  DATA_WIDTH  signed operand A.
- in_b  in  DATA_WIDTH  signed operand B.
- mul_ce  out  1  multiplier clock enable.
- mul_din0  out  DATA_WIDTH  multiplier operand 0; combinationally equal to in_a.
- mul_din1  out  DATA_WIDTH  multiplier operand 1; combinationally equal to in_b.
- mul_dout  in  DATA_WIDTH  multiplier product, low DATA_WIDTH bits, registered.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_WIDTH  saturated dot product.
- out_sat  out  1  out_data was clipped.

## Operation
- States:
  - ACCUM: collect pairs.
  - DRAIN: all VEC_LEN pairs accepted, products still in flight.
  - OUTPUT: result held.
- Accept = in_valid & in_ready.
- in_ready = (state == ACCUM) & (count < VEC_LEN) & ~reset.
- mul_ce = (state != OUTPUT). It is high even when idle; garbage slots carry tag 0.
- Tag shift register tag[MUL_LATENCY-1:0] advances only when mul_ce=1.
  - tag[0] <= accept.
  - tag[i] <= tag[i-1].
- When tag[MUL_LATENCY-1]=1 and mul_ce=1, acc <= acc + sign_extend(mul_dout).
- Products are the multiplier's wrapped low DATA_WIDTH bits; no widening.
- count increments on accept.
- ACCUM -> DRAIN on the edge where the VEC_LEN-th pair is accepted.
- DRAIN -> OUTPUT on the edge that accumulates the last in-flight product, which is the last tagged slot. On that same edge:
  - out_data <= sat(acc + final product).
  - out_sat is set if clipping occurred.
  - out_valid <= 1.
- Saturation:
  - Values > 2^(DATA_WIDTH-1)-1 clip to 8191.
  - Values < -2^(DATA_WIDTH-1) clip to -8192.
  - Only the final sum is saturated; intermediate sums are never clipped.
- OUTPUT -> ACCUM on out_valid & out_ready. On that edge acc, count and out_valid clear; out_data and out_sat hold their last values.
- In OUTPUT the pipeline is frozen (mul_ce=0) and in_ready=0. out_valid, out_data and out_sat stay stable until the handshake completes.
- Reset, at any time including mid-vector: state=ACCUM, count=0, acc=0, tag=0, out_valid=0, out_data=0, out_sat=0. Products already in the multiplier are discarded via their tags.

## Timing
- Reset values: in_ready=0 and mul_ce=1 while reset is high. out_valid, out_data and out_sat are 0.
- Latency: final pair accepted at edge E.
  - Product registered in the multiplier at E+1.
  - Accumulated and out_data registered at E+2.
  - out_valid is high in the cycle after E+2.
- Throughput: one pair per cycle in ACCUM. Each vector costs VEC_LEN + MUL_LATENCY + 1 cycles minimum, including the output handshake cycle.
- The first pair of the next vector can be accepted in the cycle after the output handshake edge.
- Back-to-back accepts with in_valid bubbles are legal; bubbles only delay, they never corrupt.

## Structure
- Shared package sample_dot_pkg holds:
  - DATA_WIDTH/ACC_WIDTH defaults.
  - State enum (ACCUM, DRAIN, OUTPUT).
  - Function sat_narrow(acc) returning the {sat, data} pair.
- One sub-module is natural: sample_dot_sat, a combinational ACC_WIDTH -> DATA_WIDTH saturator with a clip flag.
- The multiplier is instantiated by the parent, not inside this block.

## Test plan
All scenarios use VEC_LEN=4, with the real multiplier connected.
- Back-to-back pairs (1,2),(3,4),(-5,6),(7,-8) -> out_data=-72, out_sat=0, out_valid high 3 cycles after the last accept.
- Same pairs with 1-3 cycle in_valid gaps -> out_data=-72; mul_ce never drops before OUTPUT.
- 4×(90,90) -> out_data=8191, out_sat=1. 4×(90,-90) -> out_data=-8192, out_sat=1.
- Product wrap: (128,128),(1,1),(0,0),(0,0) -> 16384 wraps to 0, so out_data=1, out_sat=0.
- out_ready held low 10 cycles in OUTPUT -> out_valid/out_data stable, in_ready=0, mul_ce=0. After the handshake, the next vector (1,1)×4 -> 4.
- Reset asserted after 2 of 4 pairs, then vector (2,3)×4 -> out_data=24; no residue from the aborted vector.

Source files
------------

// File: rtl/sample_dot_pkg.sv
// Shared types and helpers for the dot-product accumulation stage:
// default widths, the controller state encoding and the narrowing saturator.
package sample_dot_pkg;

    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_ACC_WIDTH  = 24;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    typedef struct packed {
        logic                             sat;
        logic signed [DEF_DATA_WIDTH-1:0] data;
    } sat_res_t;

    localparam logic signed [DEF_ACC_WIDTH-1:0] SAT_MAX =
        DEF_ACC_WIDTH'((1 << (DEF_DATA_WIDTH - 1)) - 1);
    localparam logic signed [DEF_ACC_WIDTH-1:0] SAT_MIN =
        DEF_ACC_WIDTH'(-(1 << (DEF_DATA_WIDTH - 1)));

    // Clip a default-width accumulator value into the default result width.
    function automatic sat_res_t sat_narrow(input logic signed [DEF_ACC_WIDTH-1:0] acc);
        sat_res_t res;
        res.sat  = 1'b0;
        res.data = acc[DEF_DATA_WIDTH-1:0];
        if (acc > SAT_MAX) begin
            res.sat  = 1'b1;
            res.data = DEF_DATA_WIDTH'(SAT_MAX);
        end else if (acc < SAT_MIN) begin
            res.sat  = 1'b1;
            res.data = DEF_DATA_WIDTH'(SAT_MIN);
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_dot_acc_if.sv
// Operand, multiplier and result signals of the dot-product stage.
// slave is the accumulator's view; master is the surrounding system's view.
interface sample_dot_acc_if
    import sample_dot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_a;
    logic signed [DATA_WIDTH-1:0] in_b;

    logic                         mul_ce;
    logic signed [DATA_WIDTH-1:0] mul_din0;
    logic signed [DATA_WIDTH-1:0] mul_din1;
    logic signed [DATA_WIDTH-1:0] mul_dout;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_sat;

    modport slave (
        input  in_valid, in_a, in_b, mul_dout, out_ready,
        output in_ready, mul_ce, mul_din0, mul_din1, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_a, in_b, mul_dout, out_ready,
        input  in_ready, mul_ce, mul_din0, mul_din1, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/sample_dot_sat.sv
// Combinational ACC_WIDTH -> DATA_WIDTH saturator with a clip flag.
module sample_dot_sat
    import sample_dot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    output logic signed [DATA_WIDTH-1:0] data_o,
    output logic                         sat_o
);

    generate
        if (DATA_WIDTH == DEF_DATA_WIDTH && ACC_WIDTH == DEF_ACC_WIDTH) begin : g_pkg
            sat_res_t res;
            assign res    = sat_narrow(acc_i);
            assign data_o = res.data;
            assign sat_o  = res.sat;
        end else begin : g_generic
            localparam logic signed [ACC_WIDTH-1:0] MAX_V =
                ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
            localparam logic signed [ACC_WIDTH-1:0] MIN_V =
                ACC_WIDTH'(-(1 << (DATA_WIDTH - 1)));

            always_comb begin
                sat_o  = 1'b0;
                data_o = acc_i[DATA_WIDTH-1:0];
                if (acc_i > MAX_V) begin
                    sat_o  = 1'b1;
                    data_o = DATA_WIDTH'(MAX_V);
                end else if (acc_i < MIN_V) begin
                    sat_o  = 1'b1;
                    data_o = DATA_WIDTH'(MIN_V);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sample_dot_acc.sv
// Feeds operand pairs to an external fixed-latency multiplier, tags each slot,
// accumulates VEC_LEN products and presents one saturated result per vector.
module sample_dot_acc
    import sample_dot_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int VEC_LEN     = 16,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    sample_dot_acc_if.slave  bus
);

    localparam int CW = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0] VEC_LEN_C = CW'(VEC_LEN);
    localparam logic [CW-1:0] LAST_IDX  = CW'(VEC_LEN - 1);
    // Every tag bit except the oldest; all clear means the oldest slot is the last one.
    localparam logic [MUL_LATENCY-1:0] TAG_LOWER = MUL_LATENCY'((1 << (MUL_LATENCY - 1)) - 1);

    state_t                       state_q, state_d;
    logic [CW-1:0]                count_q, count_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [MUL_LATENCY-1:0]       tag_q, tag_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_sat_q, out_sat_d;

    logic                         in_ready;
    logic                         mul_ce;
    logic                         accept;
    logic                         acc_en;
    logic                         last_slot;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [DATA_WIDTH-1:0] sat_data;
    logic                         sat_flag;

    assign in_ready = (state_q == ACCUM) && (count_q < VEC_LEN_C) && !reset;
    assign mul_ce   = (state_q != OUTPUT);
    assign accept   = bus.in_valid && in_ready;

    // Products arrive already wrapped to DATA_WIDTH; only sign extension is applied.
    assign prod_ext  = {{(ACC_WIDTH - DATA_WIDTH){bus.mul_dout[DATA_WIDTH-1]}}, bus.mul_dout};
    assign acc_sum   = acc_q + prod_ext;
    assign acc_en    = tag_q[MUL_LATENCY-1] && mul_ce;
    assign last_slot = acc_en && ((tag_q & TAG_LOWER) == '0);

    assign tag_d[0] = mul_ce ? accept : tag_q[0];

    genvar gi;
    generate
        for (gi = 1; gi < MUL_LATENCY; gi++) begin : g_tag
            assign tag_d[gi] = mul_ce ? tag_q[gi-1] : tag_q[gi];
        end
    endgenerate

    sample_dot_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat (
        .acc_i  (acc_sum),
        .data_o (sat_data),
        .sat_o  (sat_flag)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            ACCUM: begin
                if (acc_en) begin
                    acc_d = acc_sum;
                end
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (acc_en) begin
                    acc_d = acc_sum;
                end
                if (last_slot) begin
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = sat_data;
                    out_sat_d   = sat_flag;
                end
            end
            OUTPUT: begin
                // out_data/out_sat keep their values after the handshake.
                if (bus.out_ready) begin
                    state_d     = ACCUM;
                    count_d     = '0;
                    acc_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            acc_q       <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mul_ce    = mul_ce;
    assign bus.mul_din0  = bus.in_a;
    assign bus.mul_din1  = bus.in_b;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_sample_dot_acc.sv
// Bench for sample_dot_acc with VEC_LEN=4 and a behavioural 2-stage multiplier.
module tb_sample_dot_acc;

    localparam int DW = 14;
    localparam int VL = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sample_dot_acc_if #(.DATA_WIDTH(DW)) bus ();

    sample_dot_acc #(
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (24),
        .VEC_LEN     (VL),
        .MUL_LATENCY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // External multiplier: two registered stages, both gated by mul_ce, low bits kept.
    logic signed [DW-1:0] mul_p1;
    always @(posedge clk) begin
        if (bus.mul_ce) begin
            mul_p1       <= bus.mul_din0 * bus.mul_din1;
            bus.mul_dout <= mul_p1;
        end
    end

    int errors = 0;
    int checks = 0;
    int va[VL];
    int vb[VL];

    // Reference: wrap each product to DW bits, sum exactly, clip once at the end.
    task automatic model(output int d, output int s);
        int sum = 0;
        for (int i = 0; i < VL; i++) begin
            int p = va[i] * vb[i];
            int w = p & 16383;
            if (w >= 8192) w = w - 16384;
            sum = sum + w;
        end
        if (sum > 8191) begin
            d = 8191; s = 1;
        end else if (sum < -8192) begin
            d = -8192; s = 1;
        end else begin
            d = sum; s = 0;
        end
    endtask

    task automatic drive_vec(input int npairs, input int min_gap, input int max_gap);
        for (int i = 0; i < npairs; i++) begin
            int g = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
            int guard = 0;
            repeat (g) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                checks++;
                if (bus.mul_ce !== 1'b1) begin
                    errors++;
                    $display("FAIL mul_ce_gap: mul_ce=%0b expected 1", bus.mul_ce);
                end
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = DW'(va[i]);
            bus.in_b     = DW'(vb[i]);
            while (bus.in_ready !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL accept_wait: in_ready=%0b expected 1 within 20 cycles", bus.in_ready);
            end
            @(posedge clk);
        end
    endtask

    // Called right after the edge that accepted the last pair.
    task automatic collect(input int exp_d, input int exp_s, input int hold, input string name);
        logic signed [DW-1:0] expd = DW'(exp_d);
        logic signed [DW-1:0] held;
        int n = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            n++;
            if (bus.out_valid !== 1'b1) begin
                checks++;
                if (bus.mul_ce !== 1'b1) begin
                    errors++;
                    $display("FAIL %s mul_ce_drain: mul_ce=%0b expected 1", name, bus.mul_ce);
                end
            end
        end while (bus.out_valid !== 1'b1 && n < 50);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL %s latency: out_valid after %0d cycles expected 3", name, n);
        end
        checks++;
        if (bus.out_data !== expd) begin
            errors++;
            $display("FAIL %s out_data: got %0d expected %0d", name, bus.out_data, expd);
        end
        checks++;
        if (bus.out_sat !== 1'(exp_s)) begin
            errors++;
            $display("FAIL %s out_sat: got %0b expected %0d", name, bus.out_sat, exp_s);
        end
        $display("vec %s: out_data=%0d out_sat=%0b latency=%0d hold=%0d", name, bus.out_data, bus.out_sat, n, hold);
        held = bus.out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.out_sat !== 1'(exp_s)
                || bus.in_ready !== 1'b0 || bus.mul_ce !== 1'b0) begin
                errors++;
                $display("FAIL %s hold: valid=%0b data=%0d sat=%0b in_ready=%0b mul_ce=%0b expected 1/%0d/%0d/0/0",
                         name, bus.out_valid, bus.out_data, bus.out_sat, bus.in_ready, bus.mul_ce, held, exp_s);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release_valid: out_valid=%0b expected 0", name, bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release_ready: in_ready=%0b expected 1", name, bus.in_ready);
        end
        checks++;
        if (bus.out_data !== held) begin
            errors++;
            $display("FAIL %s release_data: out_data=%0d expected %0d", name, bus.out_data, held);
        end
    endtask

    task automatic set_pairs(input int a0, b0, a1, b1, a2, b2, a3, b3);
        va[0] = a0; vb[0] = b0; va[1] = a1; vb[1] = b1;
        va[2] = a2; vb[2] = b2; va[3] = a3; vb[3] = b3;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.mul_ce !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%0b mul_ce=%0b expected 0/1", bus.in_ready, bus.mul_ce);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: valid=%0b data=%0d sat=%0b expected 0/0/0", bus.out_valid, bus.out_data, bus.out_sat);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        set_pairs(1, 2, 3, 4, -5, 6, 7, -8);
        drive_vec(VL, 0, 0);
        collect(-72, 0, 0, "back_to_back");
    endtask

    task automatic test_gaps();
        set_pairs(1, 2, 3, 4, -5, 6, 7, -8);
        drive_vec(VL, 1, 3);
        collect(-72, 0, 0, "gaps");
    endtask

    task automatic test_saturation();
        set_pairs(90, 90, 90, 90, 90, 90, 90, 90);
        drive_vec(VL, 0, 0);
        collect(8191, 1, 0, "sat_pos");
        set_pairs(90, -90, 90, -90, 90, -90, 90, -90);
        drive_vec(VL, 0, 0);
        collect(-8192, 1, 0, "sat_neg");
    endtask

    task automatic test_wrap();
        set_pairs(128, 128, 1, 1, 0, 0, 0, 0);
        drive_vec(VL, 0, 0);
        collect(1, 0, 0, "wrap");
    endtask

    task automatic test_hold();
        set_pairs(1, 2, 3, 4, -5, 6, 7, -8);
        drive_vec(VL, 0, 0);
        collect(-72, 0, 10, "hold");
        set_pairs(1, 1, 1, 1, 1, 1, 1, 1);
        drive_vec(VL, 0, 0);
        collect(4, 0, 0, "after_hold");
    endtask

    task automatic test_mid_reset();
        set_pairs(100, 50, -70, 33, 0, 0, 0, 0);
        drive_vec(2, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.mul_ce !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ctrl: in_ready=%0b mul_ce=%0b expected 0/1", bus.in_ready, bus.mul_ce);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sat !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out: valid=%0b data=%0d sat=%0b expected 0/0/0", bus.out_valid, bus.out_data, bus.out_sat);
        end
        reset = 1'b0;
        set_pairs(2, 3, 2, 3, 2, 3, 2, 3);
        drive_vec(VL, 0, 0);
        collect(24, 0, 0, "mid_reset");
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int ed, es;
            bit full = ($urandom_range(1, 0) == 1);
            for (int i = 0; i < VL; i++) begin
                if (full) begin
                    va[i] = int'($urandom_range(16383, 0)) - 8192;
                    vb[i] = int'($urandom_range(16383, 0)) - 8192;
                end else begin
                    va[i] = int'($urandom_range(200, 0)) - 100;
                    vb[i] = int'($urandom_range(200, 0)) - 100;
                end
            end
            model(ed, es);
            drive_vec(VL, 0, 2);
            collect(ed, es, int'($urandom_range(3, 0)), $sformatf("random%0d", t));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_saturation();
        test_wrap();
        test_hold();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
